// File: rtl/mul_pkg.sv
// Shared types and constants for the RV32M multiply controller.
// Optional feature macro used by mul_ctrl: MUL_CTRL_RESULT_CACHE_EN.
package mul_pkg;

  // Enable-to-completed latency of the external multiplier pipeline.
  localparam int MUL_LATENCY = 4;

  // Encoding matches the req_op port.
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } mul_state_t;

endpackage

// File: rtl/mul_fixup.sv
// Turns a 64-bit multiplier product into the 32-bit rd value.
// MULHSU is issued as unsigned*unsigned; a negative rs1 is then corrected by
// subtracting rs2 from the high word (rs1_s = rs1_u - 2^32 when rs1[31]=1).
module mul_fixup
  import mul_pkg::*;
(
  input  mul_op_t     op,
  input  logic        rs1_sign,
  input  logic [31:0] rs2,
  input  logic [63:0] p,
  output logic [31:0] rd
);

  // Select lo/hi word and apply the mixed-sign correction.
  // NOTE: rd gets a value before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rd = p[63:32];
    case (op)
      MUL:     rd = p[31:0];
      MULHSU:  rd = p[63:32] - (rs1_sign ? rs2 : 32'd0);
      default: rd = p[63:32];
    endcase
  end

endmodule

// File: rtl/mul_ctrl.sv
// Execute-side controller for RV32M multiplies in front of a fixed-latency
// multiplier. One op in flight; result returned with its tag over valid/ready.
// Optional result cache: define MUL_CTRL_RESULT_CACHE_EN.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             mul_enable,
  output logic             mul_is_signed,
  output logic [31:0]      mul_s,
  output logic [31:0]      mul_t,
  input  logic             mul_completed,
  input  logic [63:0]      mul_d
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  mul_state_t       state, state_nxt;
  logic [CNT_W-1:0] drain_cnt;
  mul_op_t          req_op_e;
  mul_op_t          op_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             complete;
  logic             cache_hit;
  mul_op_t          fix_op;
  logic             fix_sign;
  logic [31:0]      fix_rs2;
  logic [63:0]      fix_p;
  logic [31:0]      fix_rd;

  assign req_op_e = mul_op_t'(req_op);
  assign accept   = (state == IDLE) && req_valid && !flush;
  // A flush in the completion cycle still kills the op.
  assign complete = (state == WAIT) && mul_completed && !flush;

`ifdef MUL_CTRL_RESULT_CACHE_EN
  logic        cache_valid;
  logic [31:0] cache_rs1;
  logic [31:0] cache_rs2;
  logic        cache_signed;
  logic [63:0] cache_p;

  // Only MULH runs the multiplier signed; the other three share one product.
  assign cache_hit = cache_valid && (req_rs1 == cache_rs1) && (req_rs2 == cache_rs2) &&
                     ((req_op_e == MULH) == cache_signed);

  // Cache valid bit: set by a clean completion, cleared by any flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cache_valid <= 1'b0;
    else if (flush)    cache_valid <= 1'b0;
    else if (complete) cache_valid <= 1'b1;
  end

  // Cache payload.
  // NOTE: payload has no reset; it is never read while cache_valid is low.
  always_ff @(posedge clk) begin
    if (complete) begin
      cache_rs1    <= mul_s;
      cache_rs2    <= mul_t;
      cache_signed <= mul_is_signed;
      cache_p      <= mul_d;
    end
  end

  // Fixup inputs: incoming request + cached product on a hit, in-flight op otherwise.
  always_comb begin
    fix_op   = op_q;
    fix_sign = mul_s[31];
    fix_rs2  = mul_t;
    fix_p    = mul_d;
    if (state == IDLE) begin
      fix_op   = req_op_e;
      fix_sign = req_rs1[31];
      fix_rs2  = req_rs2;
      fix_p    = cache_p;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign fix_op    = op_q;
  assign fix_sign  = mul_s[31];
  assign fix_rs2   = mul_t;
  assign fix_p     = mul_d;
`endif

  mul_fixup u_fixup (
    .op       (fix_op),
    .rs1_sign (fix_sign),
    .rs2      (fix_rs2),
    .p        (fix_p),
    .rd       (fix_rd)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DRAIN;
    else     state <= state_nxt;
  end

  // Next-state and handshake/issue outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mul_enable = 1'b0;
    case (state)
      DRAIN: begin
        if (drain_cnt == CNT_W'(LATENCY)) state_nxt = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = cache_hit ? RESP : ISSUE;
      end
      ISSUE: begin
        mul_enable = 1'b1;
        state_nxt  = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (flush)              state_nxt = DRAIN;
        else if (mul_completed) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (flush || resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = DRAIN;
    endcase
  end

  // Drain counter: restarts on every entry to DRAIN so a killed op's
  // completion always falls inside the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        drain_cnt <= '0;
    else if (state_nxt == DRAIN && state != DRAIN)  drain_cnt <= '0;
    else if (state == DRAIN)                        drain_cnt <= drain_cnt + CNT_W'(1);
  end

  // Request capture and multiplier operands; operands change only for ops
  // that will actually be issued, so they hold across cache hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= MUL;
      tag_q         <= '0;
      mul_s         <= '0;
      mul_t         <= '0;
      mul_is_signed <= 1'b0;
    end else if (accept) begin
      op_q  <= req_op_e;
      tag_q <= req_tag;
      if (!cache_hit) begin
        mul_s         <= req_rs1;
        mul_t         <= req_rs2;
        mul_is_signed <= (req_op_e == MULH);
      end
    end
  end

  // Response registers: loaded on completion or on a cache hit at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data <= '0;
      resp_tag  <= '0;
    end else if (accept && cache_hit) begin
      resp_data <= fix_rd;
      resp_tag  <= req_tag;
    end else if (complete) begin
      resp_data <= fix_rd;
      resp_tag  <= tag_q;
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with a 4-stage multiplier model.
// Works with or without MUL_CTRL_RESULT_CACHE_EN defined.
module tb_mul_ctrl;
  import mul_pkg::*;

  localparam int TAG_W = 5;
  localparam int LAT   = MUL_LATENCY;
`ifdef MUL_CTRL_RESULT_CACHE_EN
  localparam int HIT_LAT  = 1;
  localparam int EN_DELTA = 0;
`else
  localparam int HIT_LAT  = LAT + 2;
  localparam int EN_DELTA = 1;
`endif

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             mul_enable;
  logic             mul_is_signed;
  logic [31:0]      mul_s;
  logic [31:0]      mul_t;
  logic             mul_completed;
  logic [63:0]      mul_d;

  mul_ctrl #(.LATENCY(LAT), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_tag       (req_tag),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_tag      (resp_tag),
    .mul_enable    (mul_enable),
    .mul_is_signed (mul_is_signed),
    .mul_s         (mul_s),
    .mul_t         (mul_t),
    .mul_completed (mul_completed),
    .mul_d         (mul_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiplier model (done pipeline is not reset) ----------
  logic [3:0]  pv = 4'b1011;
  logic [63:0] pd [4];
  logic        spur = 1'b0;
  logic [63:0] spur_d = '0;

  function automatic logic [63:0] model_prod(input logic [31:0] s, input logic [31:0] t,
                                             input logic sg);
    logic [63:0] xs, xt;
    xs = sg ? {{32{s[31]}}, s} : {32'd0, s};
    xt = sg ? {{32{t[31]}}, t} : {32'd0, t};
    return xs * xt;
  endfunction

  initial for (int i = 0; i < 4; i++) pd[i] = 64'h0123_4567_89AB_CDEF;

  always @(posedge clk) begin
    pv    <= {pv[2:0], mul_enable};
    pd[0] <= model_prod(mul_s, mul_t, mul_is_signed);
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end

  assign mul_completed = pv[3] | spur;
  assign mul_d         = spur ? spur_d : pd[3];

  // ---------------- reference for rd (sign-extend then 64-bit multiply) ----
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == MULH || op == MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    xb = (op == MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = xa * xb;
    return (op == MUL) ? p[31:0] : p[63:32];
  endfunction

  // ---------------- checking infrastructure --------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t sb_q [$];

  int en_cnt = 0;
  int rv_cnt = 0;

  // Response monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    exp_t e;
    if (mul_enable) en_cnt++;
    if (resp_valid) rv_cnt++;
    if (!rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp: data 0x%0h tag %0d with empty scoreboard", resp_data, resp_tag);
      end else begin
        e = sb_q.pop_front();
        check("resp_data", 64'(resp_data), 64'(e.data));
        check("resp_tag", 64'(resp_tag), 64'(e.tag));
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 0);
    check({tag, "_resp_data"}, 64'(resp_data), 0);
    check({tag, "_resp_tag"}, 64'(resp_tag), 0);
    check({tag, "_mul_enable"}, 64'(mul_enable), 0);
    check({tag, "_mul_is_signed"}, 64'(mul_is_signed), 0);
    check({tag, "_mul_s"}, 64'(mul_s), 0);
    check({tag, "_mul_t"}, 64'(mul_t), 0);
  endtask

  // Counts negedges with req_ready low until it rises.
  task automatic drain_check(input string name);
    int n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
    check(name, 64'(n), 64'(LAT + 1));
  endtask

  task automatic accept_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag, input logic [31:0] exp,
                            input bit push, output int a_cyc);
    bit got = 1'b0;
    a_cyc = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got   = 1'b1;
        a_cyc = cyc;
        if (push) sb_q.push_back('{exp, tag});
        break;
      end
    end
    check("accept", 64'(got), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_first_resp(input int a_cyc, input int exp_lat, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        check(name, 64'(cyc - a_cyc), 64'(exp_lat));
        break;
      end
    end
    check({name, "_seen"}, 64'(got), 1);
  endtask

  task automatic wait_enable();
    bit got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mul_enable) begin
        got = 1'b1;
        break;
      end
    end
    check("enable_seen", 64'(got), 1);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [11];
    int   a, en0, rv0;
    logic [31:0] x, y;

    vecs[0] = '{MUL,    32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB};
    vecs[1] = '{MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
    vecs[2] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
    vecs[3] = '{MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF};
    vecs[4] = '{MULHSU, 32'd2,         32'hFFFF_FFFF, 5'd5,  32'h0000_0001};
    vecs[5] = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000};
    vecs[6] = '{MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    for (int i = 7; i < 11; i++) begin
      vecs[i].op  = 2'($urandom_range(0, 3));
      vecs[i].rs1 = $urandom();
      vecs[i].rs2 = $urandom();
      vecs[i].tag = TAG_W'(i);
      vecs[i].exp = ref_mul(vecs[i].op, vecs[i].rs1, vecs[i].rs2);
    end

    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0;
    req_tag = '0; flush = 1'b0; resp_ready = 1'b1;

    // Reset values, then the post-reset drain window.
    repeat (2) @(negedge clk);
    check_zero_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    drain_check("drain_after_rst");

    // Table-driven ops: data/tag via scoreboard, first resp_valid at A+6.
    for (int i = 0; i < 11; i++) begin
      accept_req(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].tag, vecs[i].exp, 1'b1, a);
      wait_first_resp(a, LAT + 2, $sformatf("vec%0d_latency", i));
    end

    // Stray completed in IDLE is ignored.
    @(posedge clk); #1;
    spur = 1'b1; spur_d = 64'hAAAA_5555_1234_5678;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    check("stray_completed_resp_valid", 64'(resp_valid), 0);
    check("stray_completed_req_ready", 64'(req_ready), 1);

    // Consumer stalls 3 cycles in RESP.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    accept_req(MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 1'b1, a);
    wait_first_resp(a, LAT + 2, "stall_latency");
    en0 = en_cnt;
    for (int k = 0; k < 3; k++) begin
      check("stall_resp_valid", 64'(resp_valid), 1);
      check("stall_resp_data", 64'(resp_data), 64'h0000_0000_FFFF_FFEB);
      check("stall_resp_tag", 64'(resp_tag), 3);
      check("stall_req_ready", 64'(req_ready), 0);
      if (k < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(posedge clk);
    check("stall_no_reissue", 64'(en_cnt), 64'(en0));
    check("stall_sb_empty", 64'(sb_q.size()), 0);

    // Flush two cycles after mul_enable; killed op must never respond.
    accept_req(MUL, 32'd5, 32'd6, 5'd7, 32'd30, 1'b0, a);
    wait_enable();
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    rv0 = rv_cnt;
    drain_check("drain_after_flush");
    check("flush_no_resp", 64'(rv_cnt), 64'(rv0));
    accept_req(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE, 1'b1, a);
    wait_first_resp(a, LAT + 2, "after_flush_latency");

    // Flush while holding a response.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    accept_req(MULH, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 1'b1, a);
    wait_first_resp(a, LAT + 2, "resp_flush_latency");
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("resp_flush_valid_drop", 64'(resp_valid), 0);
    check("resp_flush_idle", 64'(req_ready), 1);
    @(posedge clk); #1;
    resp_ready = 1'b1;

    // Flush together with req_valid in IDLE: nothing accepted.
    en0 = en_cnt;
    req_valid = 1'b1; req_op = MUL; req_rs1 = 32'd3; req_rs2 = 32'd3; req_tag = 5'd8;
    flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_wins_req_ready", 64'(req_ready), 1);
    check("flush_wins_no_issue", 64'(en_cnt), 64'(en0));
    check("flush_wins_no_resp", 64'(resp_valid), 0);

    // Reset in the middle of WAIT.
    accept_req(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 32'd0, 1'b0, a);
    wait_enable();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    drain_check("drain_after_rst_mid");

    // MULHU then MUL on the same operands (cache hit when enabled).
    x = 32'h0001_2345;
    y = 32'hFFFF_0003;
    accept_req(MULHU, x, y, 5'd12, ref_mul(MULHU, x, y), 1'b1, a);
    wait_first_resp(a, LAT + 2, "reuse_first_latency");
    en0 = en_cnt;
    accept_req(MUL, x, y, 5'd13, ref_mul(MUL, x, y), 1'b1, a);
    wait_first_resp(a, HIT_LAT, "reuse_second_latency");
    @(posedge clk);
    check("reuse_issue_count", 64'(en_cnt - en0), 64'(EN_DELTA));

    repeat (2) @(negedge clk);
    check("final_sb_empty", 64'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
